// File: rtl/avsdadc_sar_ctrl.sv
// Successive-approximation ADC controller driving a WIDTH-bit trial DAC and sampling an external comparator.
// Optional free-running mode: define AVSDADC_CONT_CONV_EN to restart sampling directly after every DONE.
module avsdadc_sar_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             comp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  // state  | meaning
  // IDLE   | waiting for start; dac_code holds the last final code
  // SAMPLE | sample_en high, dac_code = 0, SAMPLE_CYCLES cycles
  // TRIAL  | trial code for bit_idx held SETTLE_CYCLES cycles, then decide
  // DONE   | one cycle: done pulse, result/valid already updated
  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

  localparam int MAX_CYC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] TOP_IDX     = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] LSB         = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB         = LSB << (WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_dec;
  logic [WIDTH-1:0] next_mask;

  // dac_code is acc with the trial bit set, so a kept bit equals the trial code itself
  always_comb begin
    acc_dec   = comp_in ? dac_code : acc;
    next_mask = LSB << (bit_idx - IDX_W'(1));
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      acc       <= '0;
      sample_en <= 1'b0;
      dac_code  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= SAMPLE;
            busy      <= 1'b1;
            sample_en <= 1'b1;
            dac_code  <= '0;
            acc       <= '0;
            cnt       <= SAMPLE_LOAD;
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            state     <= TRIAL;
            sample_en <= 1'b0;
            bit_idx   <= TOP_IDX;
            dac_code  <= MSB;
            cnt       <= SETTLE_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        TRIAL: begin
          if (cnt == '0) begin
            acc <= acc_dec;
            if (bit_idx == '0) begin
              state    <= DONE;
              dac_code <= acc_dec;
              result   <= acc_dec;
              done     <= 1'b1;
              valid    <= 1'b1;
            end else begin
              bit_idx  <= bit_idx - IDX_W'(1);
              dac_code <= acc_dec | next_mask;
              cnt      <= SETTLE_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
`ifdef AVSDADC_CONT_CONV_EN
          state     <= SAMPLE;
          sample_en <= 1'b1;
          dac_code  <= '0;
          acc       <= '0;
          cnt       <= SAMPLE_LOAD;
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avsdadc_sar_ctrl.sv
// Self-checking bench for avsdadc_sar_ctrl with an ideal comparator and a binary-search reference model.
module tb_avsdadc_sar_ctrl;
  localparam int W   = 10;
  localparam int S   = 4;
  localparam int T   = 2;
  localparam int LAT = S + W * T + 1;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic         comp_in;
  logic         sample_en;
  logic [W-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         valid;

  int           vin_code;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_trial [W];
  logic [W-1:0] exp_final;
  logic [W-1:0] prev_result;
  logic         prev_valid;

  avsdadc_sar_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
    .CLK(CLK), .reset(reset), .start(start), .comp_in(comp_in),
    .sample_en(sample_en), .dac_code(dac_code), .busy(busy), .done(done),
    .result(result), .valid(valid)
  );

  always #5 CLK = ~CLK;
  assign comp_in = (vin_code >= int'(dac_code));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ideal binary search: each trial sets the next bit down, kept when vin reaches it.
  task automatic sar_model(input int vin);
    int a;
    a = 0;
    for (int k = 0; k < W; k++) begin
      int trial;
      trial = a + (1 << (W - 1 - k));
      exp_trial[k] = W'(trial);
      if (vin >= trial) a = trial;
    end
    exp_final = W'(a);
  endtask

  task automatic run_conv(input int vin, input bit restart, input int abort_at);
    logic [W-1:0] exp_dac;
    sar_model(vin);
    vin_code = vin;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= LAT + 5; cyc++) begin
      if (cyc == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_result", result, 0);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_dac", dac_code, 0);
        reset = 1'b0;
        prev_result = '0;
        prev_valid  = 1'b0;
        return;
      end
      if (cyc <= S) exp_dac = '0;
      else if (cyc < LAT) exp_dac = exp_trial[(cyc - S - 1) / T];
      else exp_dac = exp_final;
      check("busy", busy, (cyc <= LAT) ? 1 : 0);
      check("done", done, (cyc == LAT) ? 1 : 0);
      check("sample_en", sample_en, (cyc <= S) ? 1 : 0);
      check("dac_code", dac_code, exp_dac);
      check("result", result, (cyc >= LAT) ? exp_final : prev_result);
      check("valid", valid, (cyc >= LAT) ? 1'b1 : prev_valid);
      start = restart && (cyc == 5 || cyc == 24);
      @(posedge CLK); #1;
    end
    start = 1'b0;
    prev_result = exp_final;
    prev_valid  = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    vin_code = 0;
    prev_result = '0;
    prev_valid  = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sample", sample_en, 0);
    check("rst_dac", dac_code, 0);
    check("rst_result", result, 0);
    check("rst_valid", valid, 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    @(posedge CLK); #1;
`ifdef AVSDADC_CONT_CONV_EN
    vin_code = 100;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 2 * LAT + 2; cyc++) begin
      check("cont_busy", busy, 1);
      check("cont_done", done, (cyc == LAT || cyc == 2 * LAT) ? 1 : 0);
      if (cyc == LAT) check("cont_res1", result, 100);
      if (cyc == 2 * LAT) check("cont_res2", result, 700);
      if (cyc == LAT + 1) vin_code = 700;
      @(posedge CLK); #1;
    end
`else
    run_conv(512, 1'b0, 0);
    check("res_512", result, 10'h200);
    run_conv(0, 1'b0, 0);
    check("res_0", result, 10'h000);
    run_conv(1023, 1'b0, 0);
    check("res_1023", result, 10'h3FF);
    run_conv(300, 1'b0, 0);
    check("res_300", result, 10'd300);
    run_conv(777, 1'b1, 0);
    run_conv(450, 1'b0, 12);
    run_conv(1, 1'b0, 0);
    for (int n = 0; n < 6; n++) run_conv(int'($urandom_range(0, 1023)), 1'b0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
